// File: rtl/rdma_stream_arbiter.sv
// rdma_stream_arbiter
//
// Packet-granular two-input round-robin arbiter in front of the RDMA packer.
// One whole packet (header beat through TLAST) is forwarded at a time, and a
// grant is never broken mid-packet. Picking a new source costs one idle
// (ARB) cycle. After that the granted stream is passed straight through to
// the packer with no added latency.
//
// Because the packer needs back-to-back valid beats after the header, any
// TVALID drop from the granted source after its first handshake raises a
// sticky GAP_ERR flag. The packet itself is still forwarded to completion.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   S0_AXIS_*           source 0 AXI-Stream slave (TDATA/TKEEP/TVALID/TLAST in, TREADY out)
//   S1_AXIS_*           source 1 AXI-Stream slave
//   M_AXIS_*            master stream to the packer (TREADY in)
//   GRANT               one-hot current grant, 2'b00 while arbitrating
//   PKT_COUNT0/1        completed-packet counters per source, wrap modulo 2^CNT_W
//   GAP_ERR             sticky mid-packet TVALID gap flag
//   GAP_CLR             clears GAP_ERR (a simultaneous new gap keeps it set)

module rdma_stream_arbiter #(
  parameter int STREAM_WB = 64,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [STREAM_WB*8-1:0] S0_AXIS_TDATA,
  input  logic [STREAM_WB-1:0]   S0_AXIS_TKEEP,
  input  logic                   S0_AXIS_TVALID,
  input  logic                   S0_AXIS_TLAST,
  output logic                   S0_AXIS_TREADY,

  input  logic [STREAM_WB*8-1:0] S1_AXIS_TDATA,
  input  logic [STREAM_WB-1:0]   S1_AXIS_TKEEP,
  input  logic                   S1_AXIS_TVALID,
  input  logic                   S1_AXIS_TLAST,
  output logic                   S1_AXIS_TREADY,

  output logic [STREAM_WB*8-1:0] M_AXIS_TDATA,
  output logic [STREAM_WB-1:0]   M_AXIS_TKEEP,
  output logic                   M_AXIS_TVALID,
  output logic                   M_AXIS_TLAST,
  input  logic                   M_AXIS_TREADY,

  output logic [1:0]             GRANT,
  output logic [CNT_W-1:0]       PKT_COUNT0,
  output logic [CNT_W-1:0]       PKT_COUNT1,
  output logic                   GAP_ERR,
  input  logic                   GAP_CLR
);

  localparam int DW = STREAM_WB * 8;

  typedef enum logic {
    ARB  = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;   // 0 = source 0, 1 = source 1
  logic             first_done_q, first_done_d;
  logic             gap_err_q, gap_err_d;
  logic [CNT_W-1:0] count0_q, count0_d;
  logic [CNT_W-1:0] count1_q, count1_d;

  logic [DW-1:0]        sel_data;
  logic [STREAM_WB-1:0] sel_keep;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 in_pass;
  logic                 beat_xfer;

  assign in_pass = (state_q == PASS);

  // Granted-source mux. Everything is gated by in_pass, so the packer sees
  // all-zero data, keep, valid and last while the arbiter is in ARB.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    if (in_pass && grant_q[0]) begin
      sel_data  = S0_AXIS_TDATA;
      sel_keep  = S0_AXIS_TKEEP;
      sel_valid = S0_AXIS_TVALID;
      sel_last  = S0_AXIS_TLAST;
    end else if (in_pass && grant_q[1]) begin
      sel_data  = S1_AXIS_TDATA;
      sel_keep  = S1_AXIS_TKEEP;
      sel_valid = S1_AXIS_TVALID;
      sel_last  = S1_AXIS_TLAST;
    end
  end

  assign M_AXIS_TDATA  = sel_data;
  assign M_AXIS_TKEEP  = sel_keep;
  assign M_AXIS_TVALID = sel_valid;
  assign M_AXIS_TLAST  = sel_last;

  // Ready to the sources depends only on the registered grant and the
  // packer's ready. It never depends on a source's own TVALID.
  assign S0_AXIS_TREADY = in_pass & grant_q[0] & M_AXIS_TREADY;
  assign S1_AXIS_TREADY = in_pass & grant_q[1] & M_AXIS_TREADY;

  assign beat_xfer = sel_valid & M_AXIS_TREADY;

  // Next-state logic. In ARB, a tie goes to whichever source did not win the
  // previous packet. In PASS, the grant is held until the TLAST handshake.
  // GAP_CLR is applied first so that a gap seen in the same cycle still sets
  // the flag.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_done_d = first_done_q;
    count0_d     = count0_q;
    count1_d     = count1_q;
    gap_err_d    = gap_err_q & ~GAP_CLR;

    case (state_q)
      ARB: begin
        grant_d      = 2'b00;
        first_done_d = 1'b0;
        if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
          grant_d = last_grant_q ? 2'b01 : 2'b10;
          state_d = PASS;
        end else if (S0_AXIS_TVALID) begin
          grant_d = 2'b01;
          state_d = PASS;
        end else if (S1_AXIS_TVALID) begin
          grant_d = 2'b10;
          state_d = PASS;
        end
      end

      PASS: begin
        if (first_done_q && !sel_valid) begin
          gap_err_d = 1'b1;
        end
        if (beat_xfer) begin
          if (sel_last) begin
            if (grant_q[0]) begin
              count0_d = count0_q + CNT_W'(1);
            end else begin
              count1_d = count1_q + CNT_W'(1);
            end
            last_grant_d = grant_q[1];
            grant_d      = 2'b00;
            first_done_d = 1'b0;
            state_d      = ARB;
          end else begin
            first_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ARB;
        grant_d = 2'b00;
      end
    endcase
  end

  // State register. Reset leaves last_grant pointing at source 1 so that
  // source 0 wins the first tie. A packet cut off by reset is simply dropped
  // and is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      first_done_q <= 1'b0;
      gap_err_q    <= 1'b0;
      count0_q     <= '0;
      count1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_done_q <= first_done_d;
      gap_err_q    <= gap_err_d;
      count0_q     <= count0_d;
      count1_q     <= count1_d;
    end
  end

  assign GRANT      = grant_q;
  assign PKT_COUNT0 = count0_q;
  assign PKT_COUNT1 = count1_q;
  assign GAP_ERR    = gap_err_q;

  // Structural invariants of the grant and ready outputs.
  a_grant_not_both : assert property (@(posedge clk) disable iff (reset) grant_q != 2'b11);
  a_grant_idle_arb : assert property (@(posedge clk) disable iff (reset) !in_pass |-> grant_q == 2'b00);
  a_grant_in_pass  : assert property (@(posedge clk) disable iff (reset) in_pass |-> $onehot(grant_q));
  a_ready_exclusive: assert property (@(posedge clk) disable iff (reset) !(S0_AXIS_TREADY && S1_AXIS_TREADY));

endmodule

// File: tb/tb_rdma_stream_arbiter.sv
// tb_rdma_stream_arbiter
//
// Self-checking bench for rdma_stream_arbiter. Sources are driven from
// per-source packet descriptor queues. A transaction-level reference model
// works out, from the arbitration rules, which source owns the output and
// which beat must appear next. It also keeps the expected packet counts and
// the sticky gap flag. Directed scenarios then inspect the logged grant and
// completion order.

module tb_rdma_stream_arbiter;

  localparam int WB = 8;
  localparam int DW = WB * 8;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] S0_AXIS_TDATA,  S1_AXIS_TDATA,  M_AXIS_TDATA;
  logic [WB-1:0] S0_AXIS_TKEEP,  S1_AXIS_TKEEP,  M_AXIS_TKEEP;
  logic          S0_AXIS_TVALID, S1_AXIS_TVALID, M_AXIS_TVALID;
  logic          S0_AXIS_TLAST,  S1_AXIS_TLAST,  M_AXIS_TLAST;
  logic          S0_AXIS_TREADY, S1_AXIS_TREADY, M_AXIS_TREADY;
  logic [1:0]    GRANT;
  logic [CW-1:0] PKT_COUNT0, PKT_COUNT1;
  logic          GAP_ERR;
  logic          GAP_CLR;

  rdma_stream_arbiter #(.STREAM_WB(WB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .S0_AXIS_TDATA(S0_AXIS_TDATA), .S0_AXIS_TKEEP(S0_AXIS_TKEEP),
    .S0_AXIS_TVALID(S0_AXIS_TVALID), .S0_AXIS_TLAST(S0_AXIS_TLAST),
    .S0_AXIS_TREADY(S0_AXIS_TREADY),
    .S1_AXIS_TDATA(S1_AXIS_TDATA), .S1_AXIS_TKEEP(S1_AXIS_TKEEP),
    .S1_AXIS_TVALID(S1_AXIS_TVALID), .S1_AXIS_TLAST(S1_AXIS_TLAST),
    .S1_AXIS_TREADY(S1_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .GRANT(GRANT), .PKT_COUNT0(PKT_COUNT0), .PKT_COUNT1(PKT_COUNT1),
    .GAP_ERR(GAP_ERR), .GAP_CLR(GAP_CLR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Pending packets per source: length and the beat index preceded by a one-cycle TVALID drop (-1 = none).
  int len_q[2][$];
  int gap_q[2][$];
  bit rand_start;

  // Source driver state for the packet currently being offered.
  bit            act[2];
  int            idx[2];
  int            plen[2];
  int            gap_at[2];
  bit            gap_done[2];
  bit            drv_valid[2];
  logic [DW-1:0] beat_d[2][$];
  logic [WB-1:0] beat_k[2][$];

  // Reference model: expected beats per source plus owner / fairness / counts / gap flag.
  logic [DW-1:0] exp_d[2][$];
  logic [WB-1:0] exp_k[2][$];
  bit            exp_l[2][$];
  bit            m_busy;
  int            m_src;
  int            m_last;
  bit            m_first;
  bit            m_gap;
  int            m_cnt[2];

  logic [1:0] grant_log[$];
  logic       mv_log[$];
  logic       ml_log[$];
  int         order_log[$];

  // Reset the DUT for one edge and bring the bench model back to its
  // post-reset view.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    S0_AXIS_TVALID = 1'b0; S0_AXIS_TLAST = 1'b0; S0_AXIS_TDATA = '0; S0_AXIS_TKEEP = '0;
    S1_AXIS_TVALID = 1'b0; S1_AXIS_TLAST = 1'b0; S1_AXIS_TDATA = '0; S1_AXIS_TKEEP = '0;
    M_AXIS_TREADY = 1'b0;
    GAP_CLR = 1'b0;
    for (int s = 0; s < 2; s++) begin
      len_q[s].delete(); gap_q[s].delete();
      beat_d[s].delete(); beat_k[s].delete();
      exp_d[s].delete(); exp_k[s].delete(); exp_l[s].delete();
      act[s] = 1'b0; idx[s] = 0; plen[s] = 0; gap_at[s] = -1; gap_done[s] = 1'b0;
      drv_valid[s] = 1'b0; m_cnt[s] = 0;
    end
    m_busy = 1'b0; m_src = 0; m_last = 1; m_first = 1'b0; m_gap = 1'b0;
    rand_start = 1'b0;
    grant_log.delete(); mv_log.delete(); ml_log.delete(); order_log.delete();
  endtask

  task automatic add_packet(input int s, input int len, input int gap);
    len_q[s].push_back(len);
    gap_q[s].push_back(gap);
  endtask

  // Start new packets where a source is free, and drive this cycle's beat.
  task automatic drive_sources();
    for (int s = 0; s < 2; s++) begin
      if (!act[s] && len_q[s].size() > 0 && !(rand_start && $urandom_range(0, 2) == 0)) begin
        plen[s] = len_q[s].pop_front();
        gap_at[s] = gap_q[s].pop_front();
        idx[s] = 0; gap_done[s] = 1'b0; act[s] = 1'b1;
        beat_d[s].delete(); beat_k[s].delete();
        for (int b = 0; b < plen[s]; b++) begin
          logic [DW-1:0] d;
          logic [WB-1:0] k;
          d = {$urandom, $urandom};
          k = WB'($urandom_range(1, 255));
          beat_d[s].push_back(d); beat_k[s].push_back(k);
          exp_d[s].push_back(d); exp_k[s].push_back(k); exp_l[s].push_back(b == plen[s] - 1);
        end
      end
      drv_valid[s] = act[s] && !(idx[s] == gap_at[s] && !gap_done[s]);
      if (act[s] && idx[s] == gap_at[s] && !gap_done[s]) gap_done[s] = 1'b1;
    end
    S0_AXIS_TVALID = drv_valid[0];
    S0_AXIS_TDATA  = act[0] ? beat_d[0][idx[0]] : '0;
    S0_AXIS_TKEEP  = act[0] ? beat_k[0][idx[0]] : '0;
    S0_AXIS_TLAST  = act[0] && (idx[0] == plen[0] - 1);
    S1_AXIS_TVALID = drv_valid[1];
    S1_AXIS_TDATA  = act[1] ? beat_d[1][idx[1]] : '0;
    S1_AXIS_TKEEP  = act[1] ? beat_k[1][idx[1]] : '0;
    S1_AXIS_TLAST  = act[1] && (idx[1] == plen[1] - 1);
  endtask

  // Cycle engine: drives traffic, checks every cycle against the model and
  // logs grant/valid/last. rmode: 0 ready always, 1 toggling, 2 random.
  // A partial run may stop with work outstanding; otherwise it must drain.
  task automatic run_traffic(input int max_cyc, input int rmode, input bit partial);
    int cyc;
    int g;
    bit hs;
    bit last;
    bit src_hs[2];
    logic [1:0] eg;
    cyc = 0;
    while ((len_q[0].size() > 0 || len_q[1].size() > 0 || act[0] || act[1] || m_busy) && cyc < max_cyc) begin
      drive_sources();
      case (rmode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = (cyc % 2 == 0);
        default: M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      g = m_src;
      eg = m_busy ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
      grant_log.push_back(GRANT); mv_log.push_back(M_AXIS_TVALID); ml_log.push_back(M_AXIS_TLAST);

      total++;
      if (GRANT !== eg) begin
        bad++; $display("[TB] FAIL grant cyc=%0d got=%b exp=%b", cyc, GRANT, eg);
      end
      if (!m_busy) begin
        total++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, S0_AXIS_TREADY, S1_AXIS_TREADY} !== 4'b0000) begin
          bad++; $display("[TB] FAIL arb_idle cyc=%0d got=%b exp=0000", cyc,
                          {M_AXIS_TVALID, M_AXIS_TLAST, S0_AXIS_TREADY, S1_AXIS_TREADY});
        end
        total++;
        if (M_AXIS_TDATA !== '0 || M_AXIS_TKEEP !== '0) begin
          bad++; $display("[TB] FAIL arb_data cyc=%0d got=%h/%h exp=0", cyc, M_AXIS_TDATA, M_AXIS_TKEEP);
        end
      end else begin
        total++;
        if (M_AXIS_TVALID !== drv_valid[g]) begin
          bad++; $display("[TB] FAIL mvalid cyc=%0d got=%b exp=%b", cyc, M_AXIS_TVALID, drv_valid[g]);
        end
        total++;
        if (((g == 0) ? S0_AXIS_TREADY : S1_AXIS_TREADY) !== M_AXIS_TREADY ||
            ((g == 0) ? S1_AXIS_TREADY : S0_AXIS_TREADY) !== 1'b0) begin
          bad++; $display("[TB] FAIL tready cyc=%0d got=%b%b exp_granted=%b src=%0d", cyc,
                          S1_AXIS_TREADY, S0_AXIS_TREADY, M_AXIS_TREADY, g);
        end
        if (drv_valid[g]) begin
          total++;
          if (M_AXIS_TDATA !== exp_d[g][0] || M_AXIS_TKEEP !== exp_k[g][0] || M_AXIS_TLAST !== exp_l[g][0]) begin
            bad++; $display("[TB] FAIL beat cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, M_AXIS_TDATA,
                            M_AXIS_TKEEP, M_AXIS_TLAST, exp_d[g][0], exp_k[g][0], exp_l[g][0]);
          end
        end
      end
      total++;
      if (GAP_ERR !== m_gap) begin
        bad++; $display("[TB] FAIL gap_err cyc=%0d got=%b exp=%b", cyc, GAP_ERR, m_gap);
      end
      total++;
      if (PKT_COUNT0 !== CW'(m_cnt[0]) || PKT_COUNT1 !== CW'(m_cnt[1])) begin
        bad++; $display("[TB] FAIL counts cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, PKT_COUNT0, PKT_COUNT1,
                        m_cnt[0], m_cnt[1]);
      end

      // Advance the model to the next edge.
      hs = m_busy && drv_valid[g] && M_AXIS_TREADY;
      if (!m_busy) begin
        if (drv_valid[0] && drv_valid[1]) begin m_src = 1 - m_last; m_busy = 1'b1; end
        else if (drv_valid[0])            begin m_src = 0;          m_busy = 1'b1; end
        else if (drv_valid[1])            begin m_src = 1;          m_busy = 1'b1; end
      end else begin
        if (m_first && !drv_valid[g]) m_gap = 1'b1;
        if (hs && exp_d[g].size() > 0) begin
          last = exp_l[g][0];
          void'(exp_d[g].pop_front()); void'(exp_k[g].pop_front()); void'(exp_l[g].pop_front());
          if (last) begin
            m_cnt[g] = (m_cnt[g] + 1) % (1 << CW);
            m_last = g; m_busy = 1'b0; m_first = 1'b0;
            order_log.push_back(g);
          end else begin
            m_first = 1'b1;
          end
        end
      end
      src_hs[0] = drv_valid[0] && (S0_AXIS_TREADY === 1'b1);
      src_hs[1] = drv_valid[1] && (S1_AXIS_TREADY === 1'b1);
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        if (src_hs[s]) begin
          idx[s]++;
          if (idx[s] >= plen[s]) act[s] = 1'b0;
        end
      end
      cyc++;
    end
    if (!partial && (len_q[0].size() > 0 || len_q[1].size() > 0 || act[0] || act[1] || m_busy)) begin
      total++; bad++;
      $display("[TB] FAIL timeout got=busy exp=drained after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    S0_AXIS_TVALID = 1'b1; S1_AXIS_TVALID = 1'b1; M_AXIS_TREADY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({GRANT, M_AXIS_TVALID, M_AXIS_TLAST, S0_AXIS_TREADY, S1_AXIS_TREADY, GAP_ERR} !== 7'b0) begin
      bad++; $display("[TB] FAIL reset_hold got=%b exp=0000000",
                      {GRANT, M_AXIS_TVALID, M_AXIS_TLAST, S0_AXIS_TREADY, S1_AXIS_TREADY, GAP_ERR});
    end
    do_reset();
    @(negedge clk);
    total++;
    if (PKT_COUNT0 !== '0 || PKT_COUNT1 !== '0) begin
      bad++; $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", PKT_COUNT0, PKT_COUNT1);
    end
    total++;
    if ({GRANT, M_AXIS_TVALID, M_AXIS_TLAST, GAP_ERR} !== 5'b0 || M_AXIS_TDATA !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs got=%b exp=00000", {GRANT, M_AXIS_TVALID, M_AXIS_TLAST, GAP_ERR});
    end
  endtask

  task automatic test_single_source();
    logic [1:0] eg[4] = '{2'b00, 2'b01, 2'b01, 2'b01};
    logic       ev[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       el[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    add_packet(0, 3, -1);
    run_traffic(50, 0, 0);
    total++;
    if (grant_log.size() != 4) begin
      bad++; $display("[TB] FAIL single_len got=%0d exp=4", grant_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (grant_log[i] !== eg[i] || mv_log[i] !== ev[i] || ml_log[i] !== el[i]) begin
        bad++; $display("[TB] FAIL single_seq[%0d] got=%b/%b/%b exp=%b/%b/%b", i, grant_log[i], mv_log[i],
                        ml_log[i], eg[i], ev[i], el[i]);
      end
    end
    total++;
    if (PKT_COUNT0 !== CW'(1) || PKT_COUNT1 !== CW'(0)) begin
      bad++; $display("[TB] FAIL single_counts got=%0d/%0d exp=1/0", PKT_COUNT0, PKT_COUNT1);
    end
  endtask

  task automatic test_contention();
    logic [1:0] eg[6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    do_reset();
    add_packet(0, 2, -1);
    add_packet(1, 2, -1);
    run_traffic(50, 0, 0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (grant_log[i] !== eg[i]) begin
        bad++; $display("[TB] FAIL contention_grant[%0d] got=%b exp=%b", i, grant_log[i], eg[i]);
      end
    end
    total++;
    if (PKT_COUNT0 !== CW'(1) || PKT_COUNT1 !== CW'(1)) begin
      bad++; $display("[TB] FAIL contention_counts got=%0d/%0d exp=1/1", PKT_COUNT0, PKT_COUNT1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    add_packet(1, 4, -1);
    run_traffic(50, 1, 0);
    total++;
    if (order_log.size() != 1 || order_log[0] != 1 || PKT_COUNT1 !== CW'(1) || PKT_COUNT0 !== CW'(0)) begin
      bad++; $display("[TB] FAIL backpressure_done got=%0d/%0d exp=0/1", PKT_COUNT0, PKT_COUNT1);
    end
  endtask

  task automatic test_gap_error();
    do_reset();
    add_packet(0, 3, 1);
    run_traffic(50, 0, 0);
    total++;
    if (PKT_COUNT0 !== CW'(1)) begin
      bad++; $display("[TB] FAIL gap_pkt_done got=%0d exp=1", PKT_COUNT0);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (GAP_ERR !== 1'b1) begin
        bad++; $display("[TB] FAIL gap_sticky got=%b exp=1", GAP_ERR);
      end
    end
    @(posedge clk); #1;
    GAP_CLR = 1'b1;
    @(posedge clk); #1;
    GAP_CLR = 1'b0;
    @(negedge clk);
    total++;
    if (GAP_ERR !== 1'b0) begin
      bad++; $display("[TB] FAIL gap_clear got=%b exp=0", GAP_ERR);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    add_packet(0, 4, -1);
    run_traffic(3, 0, 1);
    do_reset();
    @(negedge clk);
    total++;
    if (GRANT !== 2'b00 || M_AXIS_TVALID !== 1'b0 || PKT_COUNT0 !== '0 || PKT_COUNT1 !== '0) begin
      bad++; $display("[TB] FAIL reset_mid got=%b/%b/%0d/%0d exp=00/0/0/0", GRANT, M_AXIS_TVALID,
                      PKT_COUNT0, PKT_COUNT1);
    end
    @(posedge clk); #1;
    add_packet(0, 2, -1);
    add_packet(1, 2, -1);
    run_traffic(50, 0, 0);
    total++;
    if (grant_log[1] !== 2'b01 || order_log[0] != 0) begin
      bad++; $display("[TB] FAIL reset_mid_first got=%b exp=01", grant_log[1]);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) add_packet(1, 1, -1);
    run_traffic(200, 0, 0);
    total++;
    if (PKT_COUNT1 !== CW'(1) || PKT_COUNT0 !== CW'(0) || order_log.size() != 17) begin
      bad++; $display("[TB] FAIL wrap got=%0d/%0d pkts=%0d exp=0/1 pkts=17", PKT_COUNT0, PKT_COUNT1,
                      order_log.size());
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      add_packet(0, 2, -1);
      add_packet(1, 2, -1);
    end
    run_traffic(200, 0, 0);
    total++;
    if (order_log.size() != 10) begin
      bad++; $display("[TB] FAIL fair_len got=%0d exp=10", order_log.size());
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (order_log[i] != i % 2) begin
        bad++; $display("[TB] FAIL fair_order[%0d] got=%0d exp=%0d", i, order_log[i], i % 2);
      end
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    rand_start = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 30; i++) begin
        len = $urandom_range(1, 6);
        add_packet(s, len, (len > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1);
      end
    end
    run_traffic(5000, 2, 0);
    total++;
    if (order_log.size() != 60) begin
      bad++; $display("[TB] FAIL random_pkts got=%0d exp=60", order_log.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    GAP_CLR = 1'b0;
    M_AXIS_TREADY = 1'b0;
    S0_AXIS_TDATA = '0; S0_AXIS_TKEEP = '0; S0_AXIS_TVALID = 1'b0; S0_AXIS_TLAST = 1'b0;
    S1_AXIS_TDATA = '0; S1_AXIS_TKEEP = '0; S1_AXIS_TVALID = 1'b0; S1_AXIS_TLAST = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_gap_error();
    test_reset_mid_packet();
    test_counter_wrap();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
